// File: rtl/sprite_pkg.sv
// Shared constants, layer ids and FSM states for the sprite ROM arbiter.
package sprite_pkg;

  localparam int unsigned N_REQ     = 6;
  localparam int unsigned ROM_AW    = 18;
  localparam int unsigned ROM_DEPTH = 172000;
  localparam int unsigned ROM_LAT   = 2;
  localparam int unsigned PIX_W     = 4;

  localparam logic [PIX_W-1:0] TRANSP_IDX = PIX_W'(0);
  localparam logic [PIX_W-1:0] BG_COLOR   = PIX_W'(1);

  // Layer id doubles as priority: highest id wins.
  typedef enum logic [2:0] {
    GROUND = 3'd0,
    CACTUS = 3'd1,
    PTERO  = 3'd2,
    DINO   = 3'd3,
    SCORE  = 3'd4,
    HSCORE = 3'd5,
    NONE   = 3'd7
  } layer_id_e;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StWait,
    StCheck,
    StOutput
  } state_e;

  function automatic logic addr_oob(input logic [ROM_AW-1:0] addr);
    return 32'(addr) >= ROM_DEPTH;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Pixel request, sprite ROM read port and frame-buffer write bundle.
interface sprite_rom_arbiter_if;
  import sprite_pkg::*;

  logic                    req_valid;
  logic                    req_ready;
  logic [9:0]              req_x;
  logic [9:0]              req_y;
  logic [N_REQ-1:0]        req_on;
  logic [ROM_AW*N_REQ-1:0] req_addr;

  logic [ROM_AW-1:0]       rom_addr;
  logic                    rom_rd;
  logic [PIX_W-1:0]        rom_data;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [9:0]              wr_x;
  logic [9:0]              wr_y;
  logic [PIX_W-1:0]        wr_color;
  logic [2:0]              wr_src;
  logic                    err_oob;

  // Arbiter side.
  modport slave (
    input  req_valid, req_x, req_y, req_on, req_addr, rom_data, wr_ready,
    output req_ready, rom_addr, rom_rd, wr_valid, wr_x, wr_y, wr_color, wr_src, err_oob
  );

  // Environment side: draw blocks, ROM and frame-buffer writer.
  modport master (
    output req_valid, req_x, req_y, req_on, req_addr, rom_data, wr_ready,
    input  req_ready, rom_addr, rom_rd, wr_valid, wr_x, wr_y, wr_color, wr_src, err_oob
  );

endinterface

// File: rtl/prio_pick.sv
// Highest-set-bit encoder: returns the index of the top requester.
module prio_pick #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] req_i,
  output logic [2:0]   id_o,
  output logic         found_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    id_o    = 3'd0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) begin
        id_o    = 3'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Resolves one pixel at a time by reading layers top-down from the shared sprite ROM until an
// opaque texel is found, then hands the palette index to the frame-buffer writer.
module sprite_rom_arbiter
  import sprite_pkg::*;
(
  input logic                 Clk50,
  input logic                 Reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int unsigned CntW = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;

  state_e                  state_q, state_d;
  logic [N_REQ-1:0]        pending_q, pending_d;
  logic [ROM_AW*N_REQ-1:0] addr_q, addr_d;
  logic [CntW-1:0]         wait_q, wait_d;
  logic [2:0]              cur_q, cur_d;
  logic                    rom_rd_q, rom_rd_d;
  logic [ROM_AW-1:0]       rom_addr_q, rom_addr_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [9:0]              wr_x_q, wr_x_d;
  logic [9:0]              wr_y_q, wr_y_d;
  logic [PIX_W-1:0]        wr_color_q, wr_color_d;
  logic [2:0]              wr_src_q, wr_src_d;
  logic                    err_oob_q, err_oob_d;

  logic [2:0]        sel_id, nxt_id;
  logic              sel_found, nxt_found;
  logic [ROM_AW-1:0] sel_addr, nxt_addr;

  // Candidate for the current SELECT cycle.
  prio_pick #(.N(N_REQ)) u_pick_cur (
    .req_i   (pending_q),
    .id_o    (sel_id),
    .found_o (sel_found)
  );

  // Candidate for the next cycle, used to pre-register the ROM strobe.
  prio_pick #(.N(N_REQ)) u_pick_nxt (
    .req_i   (pending_d),
    .id_o    (nxt_id),
    .found_o (nxt_found)
  );

  assign sel_addr = addr_q[sel_id*ROM_AW +: ROM_AW];
  assign nxt_addr = addr_d[nxt_id*ROM_AW +: ROM_AW];

  // FSM next-state and result datapath.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    cur_d      = cur_q;
    wr_valid_d = wr_valid_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_color_d = wr_color_q;
    wr_src_d   = wr_src_q;
    err_oob_d  = err_oob_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          pending_d = bus.req_on;
          addr_d    = bus.req_addr;
          wr_x_d    = bus.req_x;
          wr_y_d    = bus.req_y;
          state_d   = StSelect;
        end
      end
      StSelect: begin
        if (!sel_found) begin
          wr_color_d = BG_COLOR;
          wr_src_d   = NONE;
          wr_valid_d = 1'b1;
          state_d    = StOutput;
        end else begin
          pending_d[sel_id] = 1'b0;
          cur_d             = sel_id;
          if (addr_oob(sel_addr)) begin
            // Skip this layer; the next candidate is tried in the following cycle.
            err_oob_d = 1'b1;
          end else begin
            wait_d  = CntW'(ROM_LAT - 1);
            state_d = (ROM_LAT > 1) ? StWait : StCheck;
          end
        end
      end
      StWait: begin
        if (wait_q <= CntW'(1)) begin
          state_d = StCheck;
        end
        wait_d = wait_q - CntW'(1);
      end
      StCheck: begin
        if (bus.rom_data != TRANSP_IDX) begin
          wr_color_d = bus.rom_data;
          wr_src_d   = cur_q;
          wr_valid_d = 1'b1;
          state_d    = StOutput;
        end else begin
          state_d = StSelect;
        end
      end
      StOutput: begin
        if (bus.wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobe is computed one cycle ahead so the registered rom_rd coincides with the SELECT cycle.
  always_comb begin
    rom_rd_d   = (state_d == StSelect) && nxt_found && !addr_oob(nxt_addr);
    rom_addr_d = rom_rd_d ? nxt_addr : rom_addr_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      addr_q     <= '0;
      wait_q     <= '0;
      cur_q      <= '0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      wr_valid_q <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= '0;
      wr_src_q   <= NONE;
      err_oob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      cur_q      <= cur_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
      wr_src_q   <= wr_src_d;
      err_oob_q  <= err_oob_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rom_rd    = rom_rd_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.wr_color  = wr_color_q;
  assign bus.wr_src    = wr_src_q;
  assign bus.err_oob   = err_oob_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: a latency-level model predicts every ROM strobe and the pixel
// result per accepted request; directed cases pin the model with literal values.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sprite_rom_arbiter_if bus ();

  sprite_rom_arbiter dut (
    .Clk50 (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the pixel in flight.
  bit               busy = 1'b0;
  int               off;
  bit               err_m = 1'b0;
  bit               rst_seen = 1'b1;
  int               rd_off[$];
  int               rd_addr[$];
  int               oob_off[$];
  int               out_off;
  logic [PIX_W-1:0] exp_color;
  logic [2:0]       exp_src;
  logic [9:0]       exp_x, exp_y;

  // ROM contents: hashed default plus directed overrides.
  logic [PIX_W-1:0] rom_ovr[int];
  bit               hist_rd[$];
  int               hist_addr[$];

  // Directed stimulus plan.
  bit                      rand_mode = 1'b0;
  bit                      p_reset = 1'b1;
  bit                      p_valid = 1'b0;
  logic [N_REQ-1:0]        p_on = '0;
  logic [ROM_AW*N_REQ-1:0] p_addr = '0;
  logic [9:0]              p_x = '0, p_y = '0;
  int                      hold_left = 0;
  int                      reset_at_off = -1;

  // Observations of the latest pixel.
  int               obs_rd_addr[$];
  int               obs_rd_off[$];
  int               obs_out_off;
  logic [PIX_W-1:0] obs_color;
  logic [2:0]       obs_src;
  int               obs_valid_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PIX_W-1:0] rom_word(input int a);
    int h;
    if (rom_ovr.exists(a)) return rom_ovr[a];
    h = a ^ (a >> 4) ^ (a >> 9);
    if (h % 3 == 0) return TRANSP_IDX;
    return PIX_W'(h);
  endfunction

  function automatic logic [ROM_AW-1:0] rand_addr();
    if ($urandom_range(7) == 0)
      return ROM_AW'(ROM_DEPTH + $urandom_range((1 << ROM_AW) - 1 - ROM_DEPTH));
    return ROM_AW'($urandom_range(ROM_DEPTH - 1));
  endfunction

  function automatic logic [ROM_AW*N_REQ-1:0] rand_vec();
    logic [ROM_AW*N_REQ-1:0] v;
    for (int i = 0; i < int'(N_REQ); i++) v[i*ROM_AW +: ROM_AW] = rand_addr();
    return v;
  endfunction

  // Walk the layers top-down: a skip costs 1 cycle, a transparent read ROM_LAT+1 cycles.
  task automatic accept(input logic [N_REQ-1:0] on, input logic [ROM_AW*N_REQ-1:0] addr,
                        input logic [9:0] x, input logic [9:0] y);
    int t;
    int a;
    bit found;
    logic [PIX_W-1:0] w;
    rd_off.delete();
    rd_addr.delete();
    oob_off.delete();
    t = 1;
    found = 1'b0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (!found && on[i]) begin
        a = int'(addr[i*ROM_AW +: ROM_AW]);
        if (a >= int'(ROM_DEPTH)) begin
          oob_off.push_back(t);
          t++;
        end else begin
          rd_off.push_back(t);
          rd_addr.push_back(a);
          w = rom_word(a);
          if (w != TRANSP_IDX) begin
            found = 1'b1;
            out_off = t + int'(ROM_LAT) + 1;
            exp_color = w;
            exp_src = 3'(i);
          end else begin
            t += int'(ROM_LAT) + 1;
          end
        end
      end
    end
    if (!found) begin
      out_off = t + 1;
      exp_color = BG_COLOR;
      exp_src = 3'd7;
    end
    exp_x = x;
    exp_y = y;
    busy = 1'b1;
    off = 1;
    obs_rd_addr.delete();
    obs_rd_off.delete();
    obs_out_off = -1;
    obs_valid_cyc = 0;
  endtask

  // One clock: compare outputs, play the ROM, drive inputs, advance the model.
  task automatic step();
    int k;
    @(posedge clk);
    #1;
    if (rst_seen) begin
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rom_rd", bus.rom_rd, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_wr_valid", bus.wr_valid, 0);
      chk("rst_wr_x", bus.wr_x, 0);
      chk("rst_wr_y", bus.wr_y, 0);
      chk("rst_wr_color", bus.wr_color, 0);
      chk("rst_wr_src", bus.wr_src, 7);
      chk("rst_err_oob", bus.err_oob, 0);
      busy = 1'b0;
      err_m = 1'b0;
      hist_rd.delete();
      hist_addr.delete();
    end else begin
      if (busy) foreach (oob_off[j]) if (oob_off[j] == off - 1) err_m = 1'b1;
      chk("req_ready", bus.req_ready, !busy);
      k = -1;
      if (busy) foreach (rd_off[j]) if (rd_off[j] == off) k = j;
      chk("rom_rd", bus.rom_rd, k >= 0);
      if (k >= 0) chk("rom_addr", bus.rom_addr, rd_addr[k]);
      chk("wr_valid", bus.wr_valid, busy && off >= out_off);
      if (busy && off >= out_off) begin
        chk("wr_x", bus.wr_x, exp_x);
        chk("wr_y", bus.wr_y, exp_y);
        chk("wr_color", bus.wr_color, exp_color);
        chk("wr_src", bus.wr_src, exp_src);
      end
      chk("err_oob", bus.err_oob, err_m);
    end
    if (bus.rom_rd) begin
      obs_rd_addr.push_back(int'(bus.rom_addr));
      obs_rd_off.push_back(off);
    end
    if (bus.wr_valid) begin
      if (obs_out_off < 0) begin
        obs_out_off = off;
        obs_color = bus.wr_color;
        obs_src = bus.wr_src;
      end
      obs_valid_cyc++;
    end
    // ROM answers ROM_LAT cycles after the strobe; garbage otherwise.
    hist_rd.push_back(bus.rom_rd);
    hist_addr.push_back(int'(bus.rom_addr));
    if (hist_rd.size() > int'(ROM_LAT) + 1) begin
      void'(hist_rd.pop_front());
      void'(hist_addr.pop_front());
    end
    if (hist_rd.size() == int'(ROM_LAT) + 1 && hist_rd[0]) bus.rom_data = rom_word(hist_addr[0]);
    else bus.rom_data = PIX_W'($urandom);
    if (rand_mode) begin
      bus.req_valid = ($urandom_range(2) != 0);
      bus.req_on    = N_REQ'($urandom);
      bus.req_addr  = rand_vec();
      bus.req_x     = 10'($urandom);
      bus.req_y     = 10'($urandom);
      bus.wr_ready  = ($urandom_range(3) != 0);
    end else begin
      bus.req_valid = p_valid;
      bus.req_on    = p_on;
      bus.req_addr  = p_addr;
      bus.req_x     = p_x;
      bus.req_y     = p_y;
      bus.wr_ready  = 1'b1;
      if (busy && off >= out_off && hold_left > 0) begin
        bus.wr_ready = 1'b0;
        hold_left--;
      end
    end
    rst = p_reset || (busy && off == reset_at_off);
    if (rst) reset_at_off = -1;
    rst_seen = rst;
    if (!rst) begin
      if (busy) begin
        if (off >= out_off && bus.wr_ready) busy = 1'b0;
        else off++;
      end else if (bus.req_valid) begin
        accept(bus.req_on, bus.req_addr, bus.req_x, bus.req_y);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    p_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic run_dir(input logic [N_REQ-1:0] on, input logic [ROM_AW*N_REQ-1:0] addr,
                         input int hold);
    int n;
    wait_idle();
    p_on = on;
    p_addr = addr;
    p_x = 10'($urandom);
    p_y = 10'($urandom);
    p_valid = 1'b1;
    hold_left = hold;
    step();
    // Scramble inputs after acceptance; the pixel in flight must not notice.
    p_valid = 1'b0;
    p_on = N_REQ'($urandom);
    p_addr = rand_vec();
    p_x = 10'($urandom);
    p_y = 10'($urandom);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("pixel_timeout", busy, 0);
  endtask

  initial begin
    logic [ROM_AW*N_REQ-1:0] av;
    bus.req_valid = 1'b0;
    bus.req_on    = '0;
    bus.req_addr  = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.wr_ready  = 1'b0;
    bus.rom_data  = '0;
    step();
    step();
    p_reset = 1'b0;
    step();

    rom_ovr[1000] = 4'd5;
    rom_ovr[2000] = 4'd0;
    rom_ovr[3000] = 4'd0;
    rom_ovr[4000] = 4'd9;
    rom_ovr[50]   = 4'd3;

    // Opaque top layer.
    av = rand_vec();
    av[3*ROM_AW +: ROM_AW] = 18'd1000;
    run_dir(6'b001000, av, 0);
    chk("t1_rd_cnt", obs_rd_addr.size(), 1);
    chk("t1_rd_addr", obs_rd_addr.size() > 0 ? obs_rd_addr[0] : -1, 1000);
    chk("t1_rd_cyc", obs_rd_off.size() > 0 ? obs_rd_off[0] : -1, 1);
    chk("t1_out_cyc", obs_out_off, 4);
    chk("t1_color", obs_color, 5);
    chk("t1_src", obs_src, 3);

    // Two transparent fall-throughs.
    av = rand_vec();
    av[5*ROM_AW +: ROM_AW] = 18'd2000;
    av[3*ROM_AW +: ROM_AW] = 18'd3000;
    av[0*ROM_AW +: ROM_AW] = 18'd4000;
    run_dir(6'b101001, av, 0);
    chk("t2_rd_cnt", obs_rd_addr.size(), 3);
    for (int i = 0; i < obs_rd_addr.size() && i < 3; i++) begin
      chk("t2_rd_addr", obs_rd_addr[i], 2000 + 1000 * i);
      chk("t2_rd_cyc", obs_rd_off[i], 1 + 3 * i);
    end
    chk("t2_out_cyc", obs_out_off, 10);
    chk("t2_color", obs_color, 9);
    chk("t2_src", obs_src, 0);

    // No layer on: background.
    run_dir(6'b000000, rand_vec(), 0);
    chk("t3_rd_cnt", obs_rd_addr.size(), 0);
    chk("t3_out_cyc", obs_out_off, 2);
    chk("t3_color", obs_color, 1);
    chk("t3_src", obs_src, 7);

    // Out-of-range layer skipped.
    av = rand_vec();
    av[1*ROM_AW +: ROM_AW] = 18'd180000;
    av[0*ROM_AW +: ROM_AW] = 18'd50;
    run_dir(6'b000011, av, 0);
    chk("t4_err_oob", bus.err_oob, 1);
    chk("t4_rd_cnt", obs_rd_addr.size(), 1);
    chk("t4_rd_addr", obs_rd_addr.size() > 0 ? obs_rd_addr[0] : -1, 50);
    chk("t4_out_cyc", obs_out_off, 5);
    chk("t4_color", obs_color, 3);
    chk("t4_src", obs_src, 0);

    // Writer back-pressure for 5 cycles.
    av = rand_vec();
    av[3*ROM_AW +: ROM_AW] = 18'd1000;
    run_dir(6'b001000, av, 5);
    chk("t5_valid_cycles", obs_valid_cyc, 6);
    chk("t5_color", obs_color, 5);

    // Reset while waiting on the ROM aborts the pixel.
    reset_at_off = 2;
    run_dir(6'b001000, av, 0);
    chk("t6_rd_cnt", obs_rd_addr.size(), 1);
    chk("t6_no_write", obs_valid_cyc, 0);
    run_dir(6'b001000, av, 0);
    chk("t6_after_out_cyc", obs_out_off, 4);
    chk("t6_after_color", obs_color, 5);
    chk("t6_after_src", obs_src, 3);

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) step();
    rand_mode = 1'b0;
    wait_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares the single sprite ROM read port between all per-layer draw blocks: ground, cactus, pterodactyl, dino, score and high score. For each frame-buffer write pixel it accepts every layer's on-flag and ROM address. It reads the highest-priority layer first and falls through to lower layers when the returned texel is transparent. The final palette index goes to the frame-buffer writer over a valid/ready handshake. Sits between the draw_* address generators and the frame-buffer write port, on Clk50.

Parameters:
N_REQ, 6, number of requesters; index = priority, highest index wins
ROM_AW, 18, sprite ROM address width
ROM_DEPTH, 172000, valid ROM words; addresses >= this are out of range
ROM_LAT, 2, cycles from rom_rd high to rom_data valid
PIX_W, 4, palette index width
TRANSP_IDX, 0, palette index meaning transparent
BG_COLOR, 1, palette index written when no layer is opaque

Ports:
Clk50  in  1  system clock
Reset  in  1  synchronous, active-high reset
req_valid  in  1  pixel request present
req_ready  out  1  high in IDLE only
req_x  in  10  WriteX of pixel
req_y  in  10  WriteY of pixel
req_on  in  N_REQ  per-layer on flag (draw_*_on_wr != 0)
req_addr  in  ROM_AW*N_REQ  per-layer ROM address, layer i at bits [i*ROM_AW +: ROM_AW]
rom_addr  out  ROM_AW  registered ROM address
rom_rd  out  1  one-cycle read strobe
rom_data  in  PIX_W  ROM texel
wr_valid  out  1  pixel result valid
wr_ready  in  1  frame-buffer writer accepts
wr_x  out  10  latched req_x
wr_y  out  10  latched req_y
wr_color  out  PIX_W  resolved palette index
wr_src  out  3  winning layer id; 7 = none/background
err_oob  out  1  sticky, set on any out-of-range address

Behaviour:
- Reset values: state IDLE, pending mask 0, rom_rd 0, rom_addr 0, wr_valid 0, wr_x 0, wr_y 0, wr_color 0, wr_src 7, err_oob 0.
- Reset mid-operation aborts the pixel; nothing is written for it.
- Handshake: transfer when req_valid && req_ready. One pixel in flight at a time.
- Output handshake: wr_valid and wr_* stay stable until wr_ready is sampled high. req_x/req_y/req_on/req_addr are latched only at acceptance.
- FSM IDLE -> SELECT -> WAIT -> CHECK -> OUTPUT.
- IDLE: req_ready=1. On accept, latch coordinates, addresses, pending=req_on; go to SELECT.
- SELECT: pick highest set bit of pending and clear that bit.
  - No bit set: wr_color=BG_COLOR, wr_src=7, go to OUTPUT.
  - Picked address >= ROM_DEPTH: set err_oob, no ROM read, stay in SELECT for the next candidate. Each skip costs one cycle.
  - Otherwise: rom_addr<=addr, rom_rd<=1 for exactly one cycle, go to WAIT.
- WAIT: count ROM_LAT-1 cycles. rom_data is sampled in CHECK, exactly ROM_LAT cycles after the rom_rd-high cycle.
- CHECK: if rom_data != TRANSP_IDX, wr_color=rom_data, wr_src=picked id, go to OUTPUT. Else go to SELECT.
- OUTPUT: wr_valid=1. On wr_ready, deassert wr_valid and go to IDLE (req_ready high next cycle).
- Latency, cycle 0 = accept:
  - Opaque top layer: rom_rd in cycle 1, CHECK in cycle 1+ROM_LAT, wr_valid from cycle 2+ROM_LAT (4 by default).
  - Each transparent fall-through adds ROM_LAT+1 cycles.
  - No layers on: wr_valid in cycle 2.
- Throughput with wr_ready held high: one pixel per ROM_LAT+3 cycles (opaque top layer), 3 cycles when no layer is on.
- Changes to req_* after acceptance have no effect on the in-flight pixel.

Decomposition:
- Package sprite_pkg:
  - ROM_AW, PIX_W, TRANSP_IDX, BG_COLOR, ROM_DEPTH
  - layer id enum: GROUND=0, CACTUS=1, PTERO=2, DINO=3, SCORE=4, HSCORE=5, NONE=7
  - FSM state enum
- Sub-module prio_pick: combinational highest-set-bit encoder over N_REQ, outputs id and found.

Test Plan:
- req_on=0b001000, addr[3]=1000, ROM[1000]=5, wr_ready=1 -> rom_rd once at cycle 1 with rom_addr 1000; wr_valid cycle 4, wr_color 5, wr_src 3.
- req_on=0b101001, ROM at addr[5] =0, at addr[3] =0, at addr[0] =9 -> three rom_rd pulses in order 5,3,0; wr_color 9, wr_src 0; wr_valid at cycle 10.
- req_on=0 -> no rom_rd; wr_valid cycle 2, wr_color=BG_COLOR(1), wr_src 7.
- req_on=0b000011, addr[1]=180000, addr[0]=50 with ROM[50]=3 -> err_oob=1; single rom_rd at 50; wr_color 3, wr_src 0.
- wr_ready held 0 for 5 cycles in OUTPUT -> wr_* stable, req_ready 0; on wr_ready=1, IDLE next cycle.
- Reset asserted during WAIT -> next cycle all outputs at reset values, req_ready 1; the next request is processed normally.
